// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder controller.
// The master drives operands and out_ready; the slave (controller) returns results and status.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built by stepping one shared 4-bit ripple-carry adder over the operands,
// one nibble per clock (LSB first), with the inter-nibble carry held in a register.
module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] carry_s;

  // Bitwise full-adder chain
  always_comb begin
    carry_s    = 5'b0_0000;
    sum        = 4'b0000;
    carry_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d;
  logic [NIB-1:0][3:0]   b_q, b_d;
  logic [NIB-1:0][3:0]   sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [3:0]            add_sum_s;
  logic                  add_cout_s;

  ripple_adder4 u_adder (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state and datapath update; handshake flags are decoded from the next state so they stay registered
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = add_sum_s;
        carry_d      = add_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout_s;
          idx_d   = {IW{1'b0}};
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; an abort by reset simply discards the running operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= {IW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized checks of the nibble-serial adder controller at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder_ctrl #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // One WIDTH=16 operation with out_ready high; operand inputs are scrambled right after acceptance
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                       output logic [15:0] rs, output logic rc, output int lat, output int bcyc);
    bus16.a = ta; bus16.b = tb; bus16.cin = tcin;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.a = ~ta; bus16.b = ~tb; bus16.cin = ~tcin;
    lat = -1; bcyc = 0; rs = 16'h0000; rc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus16.busy) bcyc++;
      if (bus16.out_valid && lat < 0) begin
        lat = i; rs = bus16.sum; rc = bus16.cout;
      end
      if (!bus16.busy) break;
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL run16_timeout: got no out_valid, expected out_valid within 40 cycles");
    end
  endtask

  task automatic test_reset();
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0; bus16.cin = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got {in_ready,out_valid,busy,cout}=%b expected 1000",
               {bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout});
    end
    n_checks++;
    if (bus16.sum !== 16'h0000) begin
      n_fail++; $display("FAIL reset_sum: got %h expected 0000", bus16.sum);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready16=%b busy16=%b in_ready4=%b expected 1 0 1",
               bus16.in_ready, bus16.busy, bus4.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s; logic c; int lat; int bc;
    run16(16'h1234, 16'h4321, 1'b0, s, c, lat, bc);
    n_checks++;
    if ({c, s} !== 17'h0_5555) begin
      n_fail++; $display("FAIL basic_result: got %b_%h expected 0_5555", c, s);
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if (bc != 5) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc);
    end
    n_checks++;
    if (bus16.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready_after: got %b expected 1", bus16.in_ready);
    end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c; int lat; int bc;
    run16(16'hFFFF, 16'h0001, 1'b0, s, c, lat, bc);
    n_checks++;
    if ({c, s} !== 17'h1_0000) begin
      n_fail++; $display("FAIL carry_ripple: got %b_%h expected 1_0000", c, s);
    end
    run16(16'hFFFF, 16'hFFFF, 1'b1, s, c, lat, bc);
    n_checks++;
    if ({c, s} !== 17'h1_FFFF) begin
      n_fail++; $display("FAIL carry_max: got %b_%h expected 1_ffff", c, s);
    end
  endtask

  task automatic test_backpressure();
    int seen;
    bus16.a = 16'h00F0; bus16.b = 16'h0010; bus16.cin = 1'b0;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus16.out_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen == 0) begin
      n_fail++; $display("FAIL bp_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'h0100 || bus16.cout !== 1'b0 ||
          bus16.in_ready !== 1'b0 || bus16.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got ov=%b sum=%h cout=%b ir=%b busy=%b expected 1 0100 0 0 1",
                 i, bus16.out_valid, bus16.sum, bus16.cout, bus16.in_ready, bus16.busy);
      end
      if (i == 2) begin
        bus16.in_valid = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h1111;
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    n_checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b busy=%b expected 0 1 0",
               bus16.out_valid, bus16.in_ready, bus16.busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus16.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored_pulse: got busy=%b expected 0", bus16.busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] s; logic c; int lat; int bc;
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b0;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus16.sum[7:0] !== 8'hFF || bus16.busy !== 1'b1 || bus16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_partial: got sum[7:0]=%h busy=%b ov=%b expected ff 1 0",
               bus16.sum[7:0], bus16.busy, bus16.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout} !== 4'b1000 ||
        bus16.sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL midop_async_reset: got ir/ov/busy/cout=%b sum=%h expected 1000 0000",
               {bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout}, bus16.sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_no_output_%0d: got ov=%b busy=%b expected 0 0", i, bus16.out_valid, bus16.busy);
      end
    end
    run16(16'h0001, 16'h0002, 1'b1, s, c, lat, bc);
    n_checks++;
    if ({c, s} !== 17'h0_0004) begin
      n_fail++; $display("FAIL midop_after: got %b_%h expected 0_0004", c, s);
    end
  endtask

  task automatic test_back_to_back();
    int first; int second; logic prev; logic [16:0] r1; logic [16:0] r2;
    bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.cin = 1'b0;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.a = 16'h7FFF; bus16.b = 16'h0001; bus16.cin = 1'b0;
    first = -1; second = -1; prev = 1'b0; r1 = 17'h0; r2 = 17'h0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (bus16.out_valid && !prev) begin
        if (first < 0) begin
          first = i; r1 = {bus16.cout, bus16.sum};
        end else if (second < 0) begin
          second = i; r2 = {bus16.cout, bus16.sum};
          bus16.in_valid = 1'b0;
        end else begin
          bus16.in_valid = 1'b0;
        end
      end
      prev = bus16.out_valid;
    end
    bus16.in_valid = 1'b0;
    n_checks++;
    if (r1 !== 17'h1_0000) begin
      n_fail++; $display("FAIL b2b_first: got %h expected 10000", r1);
    end
    n_checks++;
    if (r2 !== 17'h0_8000) begin
      n_fail++; $display("FAIL b2b_second: got %h expected 08000", r2);
    end
    n_checks++;
    if (first != 4 || second != 10) begin
      n_fail++; $display("FAIL b2b_timing: got out_valid at %0d,%0d expected 4,10", first, second);
    end
    n_checks++;
    if (bus16.busy !== 1'b0 || bus16.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b ir=%b expected 0 1", bus16.busy, bus16.in_ready);
    end
  endtask

  task automatic test_random16();
    logic [15:0] ta; logic [15:0] tb; logic tc; logic [16:0] expv; int lat; int stall;
    for (int n = 0; n < 500; n++) begin
      ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
      expv = 17'(ta) + 17'(tb) + 17'(tc);
      bus16.a = ta; bus16.b = tb; bus16.cin = tc;
      bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (bus16.out_valid) begin lat = i; break; end
      end
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin @(posedge clk); #1; end
      n_checks++;
      if ({bus16.cout, bus16.sum} !== expv || lat != 4) begin
        n_fail++;
        $display("FAIL rand16_%0d: got %h lat %0d expected %h lat 4 (a=%h b=%h cin=%b)",
                 n, {bus16.cout, bus16.sum}, lat, expv, ta, tb, tc);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      n_checks++;
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand16_handshake_%0d: got ov=%b ir=%b expected 0 1", n, bus16.out_valid, bus16.in_ready);
      end
    end
  endtask

  task automatic test_random4();
    logic [3:0] ta; logic [3:0] tb; logic tc; logic [4:0] expv; int lat; int stall;
    for (int n = 0; n < 500; n++) begin
      ta = 4'($urandom); tb = 4'($urandom); tc = 1'($urandom);
      expv = 5'(ta) + 5'(tb) + 5'(tc);
      bus4.a = ta; bus4.b = tb; bus4.cin = tc;
      bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (bus4.out_valid) begin lat = i; break; end
      end
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin @(posedge clk); #1; end
      n_checks++;
      if ({bus4.cout, bus4.sum} !== expv || lat != 1) begin
        n_fail++;
        $display("FAIL rand4_%0d: got %h lat %0d expected %h lat 1 (a=%h b=%h cin=%b)",
                 n, {bus4.cout, bus4.sum}, lat, expv, ta, tb, tc);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
      n_checks++;
      if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand4_handshake_%0d: got ov=%b ir=%b expected 0 1", n, bus4.out_valid, bus4.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random16();
    test_random4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
